bist_vector_harness: RTL and testbench

- Sequential stimulus/response harness for the flat combinational benchmark netlists (26-input / 10-output class, x0..x25 -> y0..y9).
- Drives pseudo-random input vectors into the DUT and compacts the DUT outputs into a multiple-input signature register (MISR).
- Lets a mapped or optimised netlist be checked against its golden signature on the same clocked fabric.
- Sits between the test controller and the DUT: drives the DUT inputs and reads the DUT outputs.

---
 rtl/bist_vector_harness.sv | 191 +++++++++++++++++++
 tb/tb_bist_vector_harness.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_vector_harness.sv
// ---------------------------------------------------------------------------
// bist_vector_harness
//
// Clocked stimulus/response wrapper for flat combinational benchmark
// netlists. A 32-bit Fibonacci LFSR generates the input vectors, and a
// 16-bit MISR compacts the DUT responses into a signature. When the run
// finishes, the signature is compared against a golden value.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      run request, honoured in IDLE and DONE only
//   golden     in   16     expected signature, compared on entry to DONE
//   x_out      out  N_IN   vector driven to the DUT inputs
//   y_in       in   N_OUT  DUT outputs
//   busy       out  1      high in SEED, RUN and DRAIN
//   done       out  1      high in DONE
//   pass       out  1      signature == golden, valid while done = 1
//   signature  out  16     current MISR value
// ---------------------------------------------------------------------------
module bist_vector_harness #(
    parameter int          N_IN     = 26,
    parameter int          N_OUT    = 10,
    parameter int          PATTERNS = 1024,
    parameter int          LATENCY  = 0,
    parameter logic [31:0] SEED     = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       golden,
    output logic [N_IN-1:0]   x_out,
    input  logic [N_OUT-1:0]  y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       signature
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    // The 17-bit pattern count cannot wrap even at PATTERNS = 65535.
    localparam logic [16:0] PAT_LAST = PATTERNS[16:0];
    localparam logic [3:0]  LAT      = LATENCY[3:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q,  state_d;
    logic [31:0]       lfsr_q,   lfsr_d;
    logic [N_IN-1:0]   x_q,      x_d;
    logic [15:0]       sig_q,    sig_d;
    logic [16:0]       pat_q,    pat_d;
    logic [3:0]        wait_q,   wait_d;
    logic [3:0]        drain_q,  drain_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              pass_q,   pass_d;

    logic              capture;
    logic              launch;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] g,
                                              input logic [15:0] y);
        return {g[14:0], 1'b0} ^ (g[15] ? 16'h1021 : 16'h0000) ^ y;
    endfunction

    // wait_q counts the cycles since RUN cycle 0 and saturates at LATENCY.
    // Captures begin once the first vector has travelled through the DUT
    // pipeline. Because RUN and DRAIN together last PATTERNS + LATENCY
    // cycles, this gives exactly PATTERNS captures.
    assign capture = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (wait_q == LAT);
    assign launch  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        x_d     = x_q;
        sig_d   = capture ? misr_next(sig_q, 16'(y_in)) : sig_q;
        pat_d   = pat_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (wait_q != LAT)) begin
            wait_d = wait_q + 4'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                x_d = '0;
            end
            S_SEED: begin
                x_d     = lfsr_q[N_IN-1:0];
                lfsr_d  = lfsr_next(lfsr_q);
                pat_d   = 17'd1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (pat_q == PAT_LAST) begin
                    if (LAT != 4'd0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_d == golden);
                    end
                end else begin
                    x_d    = lfsr_q[N_IN-1:0];
                    lfsr_d = lfsr_next(lfsr_q);
                    pat_d  = pat_q + 17'd1;
                end
            end
            S_DRAIN: begin
                // x_out holds the last vector while the pipeline empties.
                if (drain_q == LAT - 4'd1) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (sig_d == golden);
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_DONE: begin
                // Signature and pass stay frozen until the next launch.
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering SEED from IDLE or DONE starts a fresh run.
        if (launch) begin
            state_d = S_SEED;
            lfsr_d  = SEED_EFF;
            sig_d   = 16'h0000;
            pat_d   = '0;
            wait_d  = '0;
            drain_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            x_q     <= '0;
            sig_q   <= 16'h0000;
            pat_q   <= '0;
            wait_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            x_q     <= x_d;
            sig_q   <= sig_d;
            pat_q   <= pat_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign x_out     = x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_bist_vector_harness.sv
// ---------------------------------------------------------------------------
// tb_bist_vector_harness
//
// Four harness instances share one clock and reset:
//   u_a  default configuration (1024 patterns, no latency); its DUT
//        response is either tied to zero or a fold of x_out
//   u_b  PATTERNS=2, y_in = 1
//   u_c  PATTERNS=1, y_in = 1
//   u_d  PATTERNS=4, LATENCY=3, y_in = x_out delayed by three cycles
// ---------------------------------------------------------------------------
module tb_bist_vector_harness;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance a
    logic        start_a = 1'b0;
    logic [15:0] golden_a = 16'h0000;
    logic [25:0] x_a;
    logic [9:0]  y_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] sig_a;
    logic        ymode = 1'b0;
    assign y_a = ymode ? (x_a[9:0] ^ x_a[25:16]) : 10'h000;

    bist_vector_harness u_a (
        .clk(clk), .rst(rst), .start(start_a), .golden(golden_a),
        .x_out(x_a), .y_in(y_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a)
    );

    // Instance b
    logic        start_b = 1'b0;
    logic [15:0] golden_b = 16'h0003;
    logic [25:0] x_b;
    logic [9:0]  y_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_b;
    assign y_b = 10'h001;

    bist_vector_harness #(.PATTERNS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .golden(golden_b),
        .x_out(x_b), .y_in(y_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b)
    );

    // Instance c
    logic        start_c = 1'b0;
    logic [15:0] golden_c = 16'h0001;
    logic [25:0] x_c;
    logic [9:0]  y_c;
    logic        busy_c, done_c, pass_c;
    logic [15:0] sig_c;
    assign y_c = 10'h001;

    bist_vector_harness #(.PATTERNS(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .golden(golden_c),
        .x_out(x_c), .y_in(y_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .signature(sig_c)
    );

    // Instance d, whose DUT is modelled as a three-stage pipeline
    logic        start_d = 1'b0;
    logic [15:0] golden_d = 16'h0005;
    logic [25:0] x_d;
    logic [9:0]  y_d;
    logic        busy_d, done_d, pass_d;
    logic [15:0] sig_d;
    logic [25:0] d1 = '0, d2 = '0, d3 = '0;
    int          bcnt_d = 0;
    assign y_d = d3[9:0];

    always @(posedge clk) begin
        d1 <= x_d;
        d2 <= d1;
        d3 <= d2;
        if (rst) bcnt_d <= 0;
        else if (busy_d) bcnt_d <= bcnt_d + 1;
    end

    bist_vector_harness #(.PATTERNS(4), .LATENCY(3)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .golden(golden_d),
        .x_out(x_d), .y_in(y_d), .busy(busy_d), .done(done_d),
        .pass(pass_d), .signature(sig_d)
    );

    // Reference model
    function automatic logic [31:0] lstep(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [15:0] mstep(input logic [15:0] g, input logic [15:0] y);
        return {g[14:0], 1'b0} ^ (g[15] ? 16'h1021 : 16'h0000) ^ y;
    endfunction

    function automatic logic [25:0] pat_at(input int k);
        logic [31:0] s = 32'h1;
        for (int i = 0; i < k; i++) s = lstep(s);
        return s[25:0];
    endfunction

    function automatic logic [15:0] fold_sig();
        logic [31:0] s = 32'h1;
        logic [15:0] g = 16'h0;
        logic [25:0] x;
        for (int i = 0; i < 1024; i++) begin
            x = s[25:0];
            g = mstep(g, {6'b0, x[9:0] ^ x[25:16]});
            s = lstep(s);
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(done_a), 32'd1);
    endtask

    logic [15:0] ref_sig;
    logic [25:0] exp_x [5] = '{26'h1, 26'h3, 26'h6, 26'hD, 26'h1B};

    initial begin
        ref_sig = fold_sig();

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_x", 32'(x_a), 0);
        chk("rst_sig", 32'(sig_a), 0);
        chk("rst_x_d", 32'(x_d), 0);
        rst = 1'b0;
        step();

        // Launch all four instances together
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; start_d = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        chk("busy_rise", 32'(busy_a), 1);
        chk("seed_done", 32'(done_a), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("x_run%0d", i), 32'(x_a), 32'(exp_x[i]));
        end

        // Short runs
        chk("b_done", 32'(done_b), 1);
        chk("b_sig", 32'(sig_b), 32'h0003);
        chk("b_pass", 32'(pass_b), 1);
        chk("c_done", 32'(done_c), 1);
        chk("c_sig", 32'(sig_c), 32'h0001);
        chk("c_pass", 32'(pass_c), 1);

        // Latency-3 run: SEED + 4 RUN + 3 DRAIN, signature 1 -> 1 -> 4 -> 5
        step(); step(); step();
        chk("d_done", 32'(done_d), 1);
        chk("d_busy_cycles", 32'(bcnt_d), 8);
        chk("d_sig", 32'(sig_d), 32'h0005);
        chk("d_pass", 32'(pass_d), 1);
        step(); step();
        chk("d_sig_frozen", 32'(sig_d), 32'h0005);

        // Zero response over the full run
        wait_done_a("a_zero_done", 1100);
        chk("a_zero_sig", 32'(sig_a), 0);
        chk("a_zero_pass", 32'(pass_a), 1);
        chk("a_busy_in_done", 32'(busy_a), 0);

        // Changing golden while in DONE must not affect pass
        golden_a = 16'h0001;
        step();
        chk("golden_change_pass", 32'(pass_a), 1);

        // start in DONE launches a new run
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("rerun_done_clr", 32'(done_a), 0);
        chk("rerun_busy", 32'(busy_a), 1);
        wait_done_a("a_zero2_done", 1100);
        chk("a_zero2_sig", 32'(sig_a), 0);
        chk("a_zero2_pass", 32'(pass_a), 0);

        // Non-trivial response; reference signature without interruptions
        ymode = 1'b1;
        golden_a = ref_sig;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done_a("a_fold_done", 1100);
        chk("a_fold_sig", 32'(sig_a), 32'(ref_sig));
        chk("a_fold_pass", 32'(pass_a), 1);

        // start during RUN is ignored
        start_a = 1'b1;
        step();             // enter SEED
        start_a = 1'b0;
        step();             // RUN cycle 0
        repeat (100) step(); // RUN cycle 100
        start_a = 1'b1;
        step();             // RUN cycle 101
        start_a = 1'b0;
        chk("start_in_run_busy", 32'(busy_a), 1);
        chk("start_in_run_x", 32'(x_a), 32'(pat_at(101)));

        // rst together with start at RUN cycle 500: reset wins
        repeat (399) step();
        chk("run500_x", 32'(x_a), 32'(pat_at(500)));
        rst = 1'b1;
        start_a = 1'b1;
        step();
        rst = 1'b0;
        start_a = 1'b0;
        chk("abort_x", 32'(x_a), 0);
        chk("abort_sig", 32'(sig_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_done", 32'(done_a), 0);
        step();
        chk("abort_stays_idle", 32'(busy_a), 0);

        // A fresh run after the abort reproduces the reference signature
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done_a("a_after_abort_done", 1100);
        chk("a_after_abort_sig", 32'(sig_a), 32'(ref_sig));
        chk("a_after_abort_pass", 32'(pass_a), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
